isq_squarer: RTL
================

// Module: isq_squarer
// PURPOSE
//  Sequential shift-add integer squarer: square = root*root, the inverse of the ISR
//  integer square-root block. Turns a WIDTH-bit root back into its 2*WIDTH-bit square.
//  Used in hardware self-check loops: ISR result -> isq_squarer -> compare with ISR input.
//  Start/busy/done handshake; one clock domain.
// PARAMETERS
//  WIDTH           32  root width; square is 2*WIDTH bits
//  BITS_PER_CYCLE  1   multiplier bits consumed per BUSY cycle; must divide WIDTH
// PORTS
//  clock      in   1          rising-edge clock
//  reset      in   1          synchronous, active-low (reset==0 clears at posedge clock)
//  start      in   1          request; sampled only in IDLE or DONE
//  root       in   WIDTH      operand; latched on the accepted start edge
//  busy       out  1          computation in progress
//  done       out  1          square valid; held until next accepted start or reset
//  square     out  2*WIDTH    result register
//  value      in   2*WIDTH    [SQUARE_CHECK_EN only] value that root claims to be sqrt of
//  root_ok    out  1          [SQUARE_CHECK_EN only] root^2 <= value < (root+1)^2
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; busy=0, done=0, square=0, root_ok=0;
//    internal mcand/mplier/acc/count cleared. Overrides everything, including mid-BUSY.
//  - States: IDLE, BUSY, DONE. N = WIDTH/BITS_PER_CYCLE.
//    IDLE: start=1 -> latch root into mcand and mplier, acc=0, count=0, -> BUSY.
//    BUSY: each edge: for j in 0..BITS_PER_CYCLE-1, if mplier[j], then
//          acc += mcand << (count*BITS_PER_CYCLE + j); shift mplier right by BITS_PER_CYCLE;
//          count++. On the edge where count reaches N: square<=final acc, -> DONE.
//          start is ignored in BUSY (no restart, no queueing).
//    DONE: done=1. start=1 -> same actions as in IDLE, done drops next edge, -> BUSY.
//  - Latency: accepted start at edge E -> done=1 and square valid after edge E+N
//    (WIDTH=32, BITS_PER_CYCLE=1: 32 cycles).
//  - busy=1 exactly in BUSY; done=1 exactly in DONE; never both high.
//  - acc is 2*WIDTH bits, unsigned; no overflow is possible (max (2^W-1)^2 < 2^(2W)).
//  - square holds its previous value during BUSY; it updates only on the completion edge.
//  - root changes after the start edge have no effect on the running operation.
//  - root=0: N BUSY cycles still run (no early exit); square=0.
// CONFIGURATION
//  SQUARE_CHECK_EN defined: adds the value input and the root_ok output. On the completion
//   edge, root_ok <= (acc <= value) && (acc + 2*mcand + 1 > value). Compute the upper
//   bound in 2*WIDTH+1 bits so that root=2^W-1 does not wrap. value is sampled on that
//   edge. root_ok is cleared on an accepted start and on reset. It is valid only with done.
//  SQUARE_CHECK_EN undefined: the value and root_ok ports and their logic are absent.
//   Square behaviour and timing are identical in both builds.
// TESTING
//  1. reset=0 for 2 edges, then reset=1 -> busy=0, done=0, square=0; no activity without start.
//  2. root=12, start pulse -> busy for 32 cycles; done=1 at edge E+32; square=144; done
//     stays high for 10 idle cycles.
//  3. root=0 -> square=0 after 32 cycles. root=32'hFFFF_FFFF -> square=64'hFFFF_FFFE_0000_0001.
//  4. root=1001, start; 5 cycles later start=1 with root=7 -> ignored; square=1_002_001 at E+32.
//  5. root=32'hFFFF_FFFC, start; reset=0 at E+4 -> all outputs 0 next edge. Then root=128,
//     start -> square=16384 at its own E+32.
//  6. [SQUARE_CHECK_EN] root=31: value=1001 -> root_ok=1; value=1024 -> root_ok=0;
//     value=960 -> root_ok=0. root=32'hFFFF_FFFF, value=64'hFFFF_FFFF_FFFF_FFFF -> root_ok=1.
//  Every case: self-check square == root*root when done=1; $display "@@@ Passed" or
//  "@@@ Incorrect".

Source files
------------

// File: rtl/isq_squarer.sv
// isq_squarer: sequential shift-add integer squarer, square = root*root, with a start/busy/done handshake.
// Optional build macro SQUARE_CHECK_EN adds the value input and the root_ok range-check output.
module isq_squarer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     root,
`ifdef SQUARE_CHECK_EN
  input  logic [2*WIDTH-1:0]   value,
  output logic                 root_ok,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   square
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic                 load;
  logic                 finish;

  // Adds the partial products selected by this cycle's multiplier bits; base is the bit weight of bits[0].
  function automatic logic [2*WIDTH-1:0] add_partials(
    input logic [2*WIDTH-1:0]        acc_in,
    input logic [WIDTH-1:0]          mc,
    input logic [BITS_PER_CYCLE-1:0] bits,
    input int                        base
  );
    logic [2*WIDTH-1:0] sum;
    sum = acc_in;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (bits[j]) sum = sum + ({{WIDTH{1'b0}}, mc} << (base + j));
    end
    return sum;
  endfunction

`ifdef SQUARE_CHECK_EN
  // (r+1)^2 = r^2 + 2r + 1 is formed one bit wider so the all-ones root cannot wrap.
  function automatic logic in_range(
    input logic [2*WIDTH-1:0] sq,
    input logic [WIDTH-1:0]   mc,
    input logic [2*WIDTH-1:0] val
  );
    logic [AW-1:0] upper;
    upper = {1'b0, sq} + {{WIDTH{1'b0}}, mc, 1'b0} + AW'(1);
    return (sq <= val) && (upper > {1'b0, val});
  endfunction
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    acc_next   = acc;
    count_next = count;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        acc_next   = add_partials(acc, mcand, mplier[BITS_PER_CYCLE-1:0],
                                  int'(count) * BITS_PER_CYCLE);
        count_next = count + CW'(1);
        if (count_next == LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Operand, accumulator and result registers; start in BUSY never reaches here.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      square  <= '0;
`ifdef SQUARE_CHECK_EN
      root_ok <= 1'b0;
`endif
    end else if (load) begin
      mcand   <= root;
      mplier  <= root;
      acc     <= '0;
      count   <= '0;
`ifdef SQUARE_CHECK_EN
      root_ok <= 1'b0;
`endif
    end else if (state == BUSY) begin
      acc    <= acc_next;
      mplier <= mplier >> BITS_PER_CYCLE;
      count  <= count_next;
      if (finish) begin
        square  <= acc_next;
`ifdef SQUARE_CHECK_EN
        root_ok <= in_range(acc_next, mcand, value);
`endif
      end
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule
